dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single banked data memory port between the pipeline MEM stage (port C) and a
//  loader/DMA requester (port D). CPU has fixed priority; a starvation counter forces a D slot.
//  Rejects misaligned accesses before they reach the banks. Tracks synchronous read returns.
//  Sits between EX/MEM pipeline register + DMA engine and the memory stage bank array.
// PARAMETERS
//  STARVE_MAX  4   consecutive cycles D may be denied while requesting before a forced D grant
//  AW          15  byte address width (bank index = addr[AW-1:2], byte lane = addr[1:0])
// PORTS
//  clk         in   1   clock, all state updates on rising edge
//  rst_n       in   1   synchronous active-low reset
//  c_req       in   1   CPU access request (load or store)
//  c_we        in   1   CPU store when 1, load when 0
//  c_addr      in   AW  CPU byte address
//  c_wdata     in   32  CPU store data
//  c_type      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  c_gnt       out  1   CPU access issued this cycle (comb)
//  c_stall     out  1   c_req & ~c_gnt; pipeline holds EX/MEM (comb)
//  d_req, d_we, d_addr[AW], d_wdata[32], d_type[3]   in   DMA request, same encoding as CPU
//  d_gnt       out  1   DMA access issued this cycle (comb)
//  c_rvalid    out  1   CPU load data valid (registered, 1 cycle after c_gnt on a load)
//  d_rvalid    out  1   DMA load data valid (registered, 1 cycle after d_gnt on a load)
//  rdata       out  32  load data, pass-through of m_rdata, qualified by c_rvalid/d_rvalid
//  c_err       out  1   1-cycle pulse: CPU request misaligned, dropped (comb)
//  d_err       out  1   1-cycle pulse: DMA request misaligned, dropped (comb)
//  m_read, m_write out 1  memory enables; mutually exclusive, at most one per cycle
//  m_addr      out  AW  memory byte address
//  m_wdata     out  32  memory store data
//  m_type      out  3   memory access type
//  m_rdata     in   32  memory load result, valid the cycle after m_read
// BEHAVIOUR
//  Reset: state=S_CPU, starve_cnt=0, c_rvalid=d_rvalid=0; with both reqs low all comb outputs 0.
//  Alignment: H/HU need addr[0]=0; W needs addr[1:0]=00; B/BU always legal; type 011/110/111
//   illegal. A misaligned/illegal request that would be granted raises its err instead of gnt,
//   issues no m_read/m_write, and is consumed (requester must drop req next cycle).
//  FSM states: S_CPU (C wins if c_req), S_DMAF (D wins if d_req, C stalled).
//   S_CPU: c_req -> grant C; else d_req -> grant D. If d_req & c_req, starve_cnt++;
//     starve_cnt==STARVE_MAX-1 and still denied -> next state S_DMAF.
//     Any D grant or d_req low clears starve_cnt.
//   S_DMAF: d_req -> grant D, c_stall=1 if c_req; return S_CPU next cycle, starve_cnt=0.
//     d_req low in S_DMAF (withdrawn) -> behave as S_CPU this cycle, return S_CPU.
//  Issue: granted port's addr/wdata/type drive m_*; m_read=gnt&~we, m_write=gnt&we. Ungranted:
//   m_* addr/wdata/type = 0.
//  Read return: owner register set on a load grant; next cycle pulses c_rvalid or d_rvalid
//   (never both); rdata=m_rdata. Back-to-back loads from alternating ports allowed every cycle.
//  Stores complete in issue cycle; no rvalid. Store followed by load to same address next cycle
//   returns new data (memory write-first order is handled by the bank array).
//  Reset mid-operation: pending rvalid is cancelled; starve_cnt and state revert immediately.
//  Latency: grant 0 cycles (comb), load data 1 cycle. Throughput 1 access/cycle total.
// TESTING
//  1 Reset: rst_n=0 two cycles with c_req=d_req=1 -> all outputs 0 while reset, c_rvalid=0.
//  2 CPU-only LW addr 0x0010 -> c_gnt same cycle, m_read=1, m_addr=0x0010; next cycle
//    c_rvalid=1, rdata=preloaded 0xDEADBEEF, d_rvalid=0.
//  3 Contention, STARVE_MAX=4, c_req,d_req held high -> C granted cycles 0-3, D granted cycle 4
//    with c_stall=1, C granted cycle 5; repeats every 5 cycles.
//  4 Misalignment: c LH addr 0x0003 -> c_err=1, c_gnt=0, m_read=0; d LW addr 0x0006 -> d_err.
//  5 Alternating loads: C LW 0x0000 cycle 0, D LBU 0x0005 cycle 1 -> c_rvalid cycle 1,
//    d_rvalid cycle 2, each rdata matching the preloaded word/zero-extended byte.
//  6 Reset asserted the cycle after a D load grant -> d_rvalid stays 0, state=S_CPU.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbitrates the banked data memory port between the CPU MEM stage (C) and a DMA/loader (D).
// C has fixed priority, a starvation counter forces a D slot, misaligned accesses are dropped.
module dmem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int AW         = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [31:0]   c_wdata,
    input  logic [2:0]    c_type,
    output logic          c_gnt,
    output logic          c_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [2:0]    d_type,
    output logic          d_gnt,
    output logic          c_rvalid,
    output logic          d_rvalid,
    output logic [31:0]   rdata,
    output logic          c_err,
    output logic          d_err,
    output logic          m_read,
    output logic          m_write,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    output logic [2:0]    m_type,
    input  logic [31:0]   m_rdata
);

    localparam logic [0:0] S_CPU  = 1'b0;
    localparam logic [0:0] S_DMAF = 1'b1;
    localparam int         CW     = $clog2(STARVE_MAX + 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          c_rv_q, d_rv_q;
    logic          sel_c, sel_d;
    logic          c_ok, d_ok;

    // Byte/unsigned-byte always legal; halfwords need addr[0]=0; words need addr[1:0]=0.
    function automatic logic access_legal(input logic [2:0] t, input logic [1:0] a);
        case (t)
            3'b000, 3'b100: access_legal = 1'b1;
            3'b001, 3'b101: access_legal = ~a[0];
            3'b010:         access_legal = (a == 2'b00);
            default:        access_legal = 1'b0;
        endcase
    endfunction

    assign c_ok = access_legal(c_type, c_addr[1:0]);
    assign d_ok = access_legal(d_type, d_addr[1:0]);

    always_comb begin
        sel_c    = 1'b0;
        sel_d    = 1'b0;
        state_d  = S_CPU;
        starve_d = starve_q;
        if (rst_n) begin
            if (state_q == S_DMAF && d_req) begin
                sel_d    = 1'b1;
                starve_d = '0;
            end else begin
                // A withdrawn forced slot falls back to normal CPU-priority arbitration.
                if (c_req) begin
                    sel_c = 1'b1;
                end else if (d_req) begin
                    sel_d = 1'b1;
                end
                if (c_req && d_req) begin
                    starve_d = starve_q + 1'b1;
                    if (starve_q == CW'(STARVE_MAX - 1)) begin
                        state_d = S_DMAF;
                    end
                end else begin
                    starve_d = '0;
                end
            end
        end
    end

    assign c_gnt   = sel_c & c_ok;
    assign c_err   = sel_c & ~c_ok;
    assign d_gnt   = sel_d & d_ok;
    assign d_err   = sel_d & ~d_ok;
    assign c_stall = rst_n & c_req & ~c_gnt;

    always_comb begin
        m_read  = 1'b0;
        m_write = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_type  = '0;
        if (c_gnt) begin
            m_read  = ~c_we;
            m_write = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
            m_type  = c_type;
        end else if (d_gnt) begin
            m_read  = ~d_we;
            m_write = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_type  = d_type;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_CPU;
            starve_q <= '0;
            c_rv_q   <= 1'b0;
            d_rv_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            c_rv_q   <= c_gnt & ~c_we;
            d_rv_q   <= d_gnt & ~d_we;
        end
    end

    // Gating with rst_n cancels a read return whose reset lands in the return cycle.
    assign c_rvalid = c_rv_q & rst_n;
    assign d_rvalid = d_rv_q & rst_n;
    assign rdata    = (c_rvalid | d_rvalid) ? m_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: driver predicts each cycle from a request-level model,
// a negedge monitor pops and compares issue outputs and read returns.
module tb_dmem_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int AW         = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] c_addr = '0, d_addr = '0;
    logic [31:0]   c_wdata = '0, d_wdata = '0;
    logic [2:0]    c_type = '0, d_type = '0;
    logic          c_gnt, c_stall, d_gnt, c_rvalid, d_rvalid, c_err, d_err, m_read, m_write;
    logic [31:0]   rdata, m_wdata;
    logic [AW-1:0] m_addr;
    logic [2:0]    m_type;
    logic [31:0]   m_rdata = '0;

    dmem_arbiter #(.STARVE_MAX(STARVE_MAX), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_type(c_type),
        .c_gnt(c_gnt), .c_stall(c_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_type(d_type),
        .d_gnt(d_gnt), .c_rvalid(c_rvalid), .d_rvalid(d_rvalid), .rdata(rdata),
        .c_err(c_err), .d_err(d_err), .m_read(m_read), .m_write(m_write),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_type(m_type), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [1:0] a, input logic [2:0] t);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[int'(a) * 8 +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (t)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [1:0] a, input logic [2:0] t, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        case (t)
            3'b000, 3'b100: r[int'(a) * 8 +: 8] = d[7:0];
            3'b001, 3'b101: r[int'(a[1]) * 16 +: 16] = d[15:0];
            default:        r = d;
        endcase
        return r;
    endfunction

    function automatic logic legal(input logic [2:0] t, input logic [AW-1:0] a);
        int sz;
        if (!(t inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
        sz = (t[1:0] == 2'b00) ? 1 : (t[1:0] == 2'b01) ? 2 : 4;
        return (int'(a) % sz) == 0;
    endfunction

    // Environment bank array, driven only by the DUT's memory port.
    logic [31:0] bank   [0:8191];
    logic [31:0] shadow [0:8191];
    always @(posedge clk) begin
        if (m_write) bank[m_addr[AW-1:2]] <= st_merge(bank[m_addr[AW-1:2]], m_addr[1:0], m_type, m_wdata);
        if (m_read)  m_rdata <= ld_ext(bank[m_addr[AW-1:2]], m_addr[1:0], m_type);
    end

    typedef struct {
        logic          c_gnt, c_stall, d_gnt, c_err, d_err, m_read, m_write;
        logic [AW-1:0] m_addr;
        logic [31:0]   m_wdata;
        logic [2:0]    m_type;
    } exp_t;

    typedef struct {
        logic        port_d;
        logic [31:0] data;
        int          due;
    } rd_t;

    exp_t eq[$];
    rd_t  rq[$];
    int   n_checks = 0, n_pass = 0;
    int   streak = 0;
    logic c_held = 1'b0, d_held = 1'b0, c_dropped = 1'b0, d_dropped = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic issue(input logic dport, input logic we, input logic [AW-1:0] a,
                         input logic [31:0] wd, input logic [2:0] t, inout exp_t e);
        rd_t r;
        e.m_read  = ~we;
        e.m_write = we;
        e.m_addr  = a;
        e.m_wdata = wd;
        e.m_type  = t;
        if (we) begin
            shadow[a[AW-1:2]] = st_merge(shadow[a[AW-1:2]], a[1:0], t, wd);
        end else begin
            r.port_d = dport;
            r.data   = ld_ext(shadow[a[AW-1:2]], a[1:0], t);
            r.due    = cyc + 1;
            rq.push_back(r);
        end
    endtask

    // Drives one cycle and predicts it: D wins once it has been passed over STARVE_MAX times in a row.
    task automatic cyc_drive(input logic rn,
                             input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [31:0] cd, input logic [2:0] ct,
                             input logic dr, input logic dw, input logic [AW-1:0] da, input logic [31:0] dd, input logic [2:0] dt);
        exp_t e;
        int   win;
        @(posedge clk);
        #1;
        rst_n = rn;
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd; c_type = ct;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_type = dt;
        e = '{default: '0};
        c_held = 1'b0; d_held = 1'b0; c_dropped = 1'b0; d_dropped = 1'b0;
        if (!rn) begin
            streak = 0;
            while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
        end else begin
            if (dr && streak >= STARVE_MAX) win = 2;
            else if (cr) win = 1;
            else if (dr) win = 2;
            else win = 0;
            streak = (dr && win != 2) ? streak + 1 : 0;
            if (win == 1) begin
                if (legal(ct, ca)) begin e.c_gnt = 1'b1; issue(1'b0, cw, ca, cd, ct, e); end
                else begin e.c_err = 1'b1; c_dropped = 1'b1; end
            end
            if (win == 2) begin
                if (legal(dt, da)) begin e.d_gnt = 1'b1; issue(1'b1, dw, da, dd, dt, e); end
                else begin e.d_err = 1'b1; d_dropped = 1'b1; end
            end
            e.c_stall = cr && !e.c_gnt;
            c_held = cr && win != 1;
            d_held = dr && win != 2;
        end
        eq.push_back(e);
    endtask

    task automatic idle(input logic rn);
        cyc_drive(rn, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (eq.size() > 0) begin
            e = eq.pop_front();
            chk("c_gnt", c_gnt, e.c_gnt);
            chk("d_gnt", d_gnt, e.d_gnt);
            chk("c_stall", c_stall, e.c_stall);
            chk("c_err", c_err, e.c_err);
            chk("d_err", d_err, e.d_err);
            chk("m_read", m_read, e.m_read);
            chk("m_write", m_write, e.m_write);
            chk("m_addr", m_addr, e.m_addr);
            chk("m_wdata", m_wdata, e.m_wdata);
            chk("m_type", m_type, e.m_type);
        end
        if (c_rvalid || d_rvalid) begin
            if (rq.size() == 0 || rq[0].due != cyc) begin
                chk("unexpected_rvalid", {c_rvalid, d_rvalid}, 2'b00);
            end else begin
                chk("rvalid_port", {c_rvalid, d_rvalid}, rq[0].port_d ? 2'b01 : 2'b10);
                chk("rdata", rdata, rq[0].data);
                void'(rq.pop_front());
            end
        end else if (rq.size() > 0 && rq[0].due <= cyc) begin
            chk("missing_rvalid", 1'b0, 1'b1);
            void'(rq.pop_front());
        end
        if (!rst_n) chk("rdata_in_reset", rdata, 32'h0);
    end

    logic [2:0] tsel [10] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b010};

    initial begin
        logic          cr, cw, dr, dw;
        logic [AW-1:0] ca, da;
        logic [31:0]   cd, dd;
        logic [2:0]    ct, dt;
        for (int i = 0; i < 8192; i++) begin
            bank[i]   = 32'h5A000000 ^ (i * 32'h01010101);
            shadow[i] = bank[i];
        end
        bank[0] = 32'h12345678;  shadow[0] = 32'h12345678;
        bank[1] = 32'hA1B2C3D4;  shadow[1] = 32'hA1B2C3D4;
        bank[4] = 32'hDEADBEEF;  shadow[4] = 32'hDEADBEEF;

        // Reset held with both requesters active.
        cyc_drive(1'b0, 1'b1, 1'b0, 15'h0010, '0, 3'b010, 1'b1, 1'b0, 15'h0004, '0, 3'b010);
        cyc_drive(1'b0, 1'b1, 1'b0, 15'h0010, '0, 3'b010, 1'b1, 1'b0, 15'h0004, '0, 3'b010);
        idle(1'b1);

        // CPU-only word load of the preloaded location.
        cyc_drive(1'b1, 1'b1, 1'b0, 15'h0010, '0, 3'b010, 1'b0, 1'b0, '0, '0, '0);
        idle(1'b1);

        // Sustained contention: D forced in every fifth cycle.
        for (int i = 0; i < 10; i++) begin
            cyc_drive(1'b1, 1'b1, 1'b0, 15'h0010, '0, 3'b010, 1'b1, 1'b0, 15'h0004, '0, 3'b010);
            #3;
            chk("starve_c_gnt", c_gnt, (i % 5) != 4);
            chk("starve_d_gnt", d_gnt, (i % 5) == 4);
        end
        idle(1'b1);

        // Misaligned halfword from C, misaligned word from D.
        cyc_drive(1'b1, 1'b1, 1'b0, 15'h0003, '0, 3'b001, 1'b0, 1'b0, '0, '0, '0);
        cyc_drive(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 15'h0006, '0, 3'b010);
        idle(1'b1);

        // Alternating-port loads on consecutive cycles.
        cyc_drive(1'b1, 1'b1, 1'b0, 15'h0000, '0, 3'b010, 1'b0, 1'b0, '0, '0, '0);
        cyc_drive(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 15'h0005, '0, 3'b100);
        idle(1'b1);

        // Store then load-back of the same word.
        cyc_drive(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 15'h0020, 32'hCAFEF00D, 3'b010);
        cyc_drive(1'b1, 1'b1, 1'b0, 15'h0020, '0, 3'b010, 1'b0, 1'b0, '0, '0, '0);
        idle(1'b1);

        // Reset arriving the cycle after a D load grant, then contention resumes at C priority.
        cyc_drive(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 15'h0010, '0, 3'b010);
        idle(1'b0);
        cyc_drive(1'b1, 1'b1, 1'b0, 15'h0000, '0, 3'b010, 1'b1, 1'b0, 15'h0004, '0, 3'b010);
        idle(1'b1);

        // Randomized traffic; stalled requesters hold, errored ones drop for a cycle.
        cr = 0; cw = 0; ca = '0; cd = '0; ct = '0;
        dr = 0; dw = 0; da = '0; dd = '0; dt = '0;
        for (int i = 0; i < 800; i++) begin
            logic rn;
            rn = ($urandom_range(0, 99) != 0);
            if (!c_held) begin
                cr = !c_dropped && ($urandom_range(0, 3) != 0);
                cw = $urandom_range(0, 2) == 0;
                ct = tsel[$urandom_range(0, 9)];
                ca = AW'($urandom_range(0, 47));
                if ($urandom_range(0, 1) == 1) ca = ca & ~AW'(ct[1] ? 3 : ct[0] ? 1 : 0);
                cd = $urandom;
            end
            if (!d_held) begin
                dr = !d_dropped && ($urandom_range(0, 2) != 0);
                dw = $urandom_range(0, 2) == 0;
                dt = tsel[$urandom_range(0, 9)];
                da = AW'($urandom_range(0, 47));
                if ($urandom_range(0, 1) == 1) da = da & ~AW'(dt[1] ? 3 : dt[0] ? 1 : 0);
                dd = $urandom;
            end
            cyc_drive(rn, cr, cw, ca, cd, ct, dr, dw, da, dd, dt);
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        @(posedge clk);
        #1;
        chk("rd_queue_drained", rq.size(), 0);
        chk("exp_queue_drained", eq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
